extio_req_demux: RTL
====================

Name: extio_req_demux

Overview:
- Request/response demultiplexer directly downstream of the ExtIO crossbar slot (ExtIOBase 0x4000_0000, length 0x1000_0000).
- Decodes each incoming request against the five I/O peripheral windows (BOOT, UART, SPI, Ethernet, GPIO) and forwards it to exactly one target port.
- Keeps responses in order by tracking outstanding transactions.
- Answers unmapped addresses from an internal error responder.

Parameters:
- MaxTrans, 4, maximum outstanding transactions; legal range 1..15.
- AddrWidth, 64, request address width.
- DataWidth, 64, data width; byte-enable width is DataWidth/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request accepted when valid&ready
- req_addr_i  in  AddrWidth  request address
- req_we_i  in  1  1 = write, 0 = read
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  DataWidth/8  byte enables
- rsp_valid_o  out  1  upstream response valid
- rsp_ready_i  in  1  upstream response accepted
- rsp_rdata_o  out  DataWidth  read data
- rsp_err_o  out  1  error response
- tgt_req_valid_o  out  5  per-target request valid, indexed by axi_extio_t
- tgt_req_ready_i  in  5  per-target request ready
- tgt_addr_o, tgt_we_o, tgt_wdata_o, tgt_be_o  out  as upstream  broadcast copies of the request fields
- tgt_rsp_valid_i  in  5  per-target response valid
- tgt_rsp_ready_o  out  5  per-target response ready
- tgt_rsp_rdata_i  in  5xDataWidth  per-target read data
- tgt_rsp_err_i  in  5  per-target error

Behaviour:
- Decode (combinational):
  - A request hits target t when (addr & ~(Length_t-1)) == Base_t.
  - Bases: BOOT 0x4000_0000, UART 0x4100_0000, SPI 0x4200_0000, Ethernet 0x4300_0000, GPIO 0x4400_0000. Every length is 0x10000.
  - Output index: GPIO=0, Ethernet=1, SPI=2, UART=3, BOOT=4.
  - No hit selects the internal error target, index 5 (ERR).
- State:
  - cnt_q, width $clog2(MaxTrans+1), resets to 0.
  - cur_q, 3 bits, resets to 0.
  - FSM states are IDLE (cnt_q==0) and BUSY (cnt_q>0).
- Accept condition: stall = (cnt_q==MaxTrans) || (cnt_q!=0 && dec!=cur_q).
  - No target switch is allowed while responses are pending. This keeps responses in order.
- Request path:
  - tgt_req_valid_o[dec] = req_valid_i & ~stall. All other valids are 0.
  - req_ready_o = ~stall & (dec==ERR ? 1 : tgt_req_ready_i[dec]). The error target always accepts.
  - Combinational pass-through, zero latency.
- Handshake:
  - On each accepted request (valid&ready), cur_q <= dec and cnt increments.
  - On each accepted response (rsp_valid_o&rsp_ready_i), cnt decrements.
  - Both in the same cycle leave cnt unchanged.
  - cnt never exceeds MaxTrans and never underflows.
- Response path with cnt_q>0 and cur_q<5:
  - rsp_valid_o, rsp_rdata_o and rsp_err_o are muxed from target cur_q.
  - tgt_rsp_ready_o[cur_q] = rsp_ready_i. All others are 0.
- Response path with cnt_q>0 and cur_q==ERR:
  - rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
  - Responses are produced earliest one cycle after acceptance, one per cycle, until cnt drains.
- Response path with cnt_q==0:
  - rsp_valid_o=0 and tgt_rsp_ready_o=0.
  - A target response arriving while idle is not forwarded.
- Reset values:
  - req_ready_o follows the accept condition combinationally; after reset it is 1 for ERR and tgt_req_ready_i[dec] otherwise.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, all tgt_req_valid_o=0, all tgt_rsp_ready_o=0.
- Reset mid-operation: cnt_q and cur_q clear immediately. In-flight transactions are dropped; target-side recovery is the targets' own reset.
- Boundary cases:
  - Address 0x4000_FFFF hits BOOT.
  - Address 0x4001_0000 goes to ERR.
  - Addresses at or above 0x4500_0000 go to ERR.
  - Full with a same-cycle response: accept is still blocked. The stall uses cnt_q, not the next value.

Decomposition:
- Shared package ariane_soc:
  - NumExtIO = 5 and ExtIOErrIdx = 5.
  - The existing axi_extio_t, the *Base and *Length constants, and the soc_iobus_start_t enum.
- Sub-module extio_addr_decode: combinational address-to-index decoder, reusable by the FPGA top.

Test Plan:
- Read to 0x4100_0010 with UART ready → tgt_req_valid_o=5'b01000. A UART response of rdata 0xDEAD_BEEF returns with err=0, and cnt goes 0→1→0.
- Four back-to-back reads to SPI with no responses (MaxTrans=4) → 4 accepted, 5th stalled (req_ready_o=0). One response returns → the 5th is accepted on the following cycle.
- SPI request outstanding, then a GPIO request issued → GPIO valid held 0 until the SPI response handshakes, then forwarded.
- Write to 0x4600_0000 → accepted in the same cycle, no tgt valid. The next cycle gives rsp_valid_o=1, err=1, rdata=0.
- Boundary addresses: 0x4000_FFFF → BOOT; 0x4001_0000 → ERR; 0x4400_FFF8 → GPIO.
- rst_ni asserted with cnt=2 → next edge cnt=0 and rsp_valid_o=0. The first post-reset request to Ethernet is forwarded immediately.

Source files
------------

// File: rtl/ariane_soc_pkg.sv
// ariane_soc: shared SoC address-map package.
// Holds the ExtIO slot window, the five I/O peripheral windows, and the
// target index encoding used by the ExtIO request demultiplexer and its
// address decoder. NumExtIO counts the real targets; ExtIOErrIdx is the
// extra index used for the internal error responder.
package ariane_soc;

    localparam int unsigned NumExtIO    = 5;
    localparam int unsigned ExtIOErrIdx = 5;

    // Target index order on the demux output vectors.
    typedef enum logic [2:0] {
        GPIO     = 3'd0,
        Ethernet = 3'd1,
        SPI      = 3'd2,
        UART     = 3'd3,
        BOOT     = 3'd4
    } axi_extio_t;

    localparam logic [63:0] ExtIOBase      = 64'h0000_0000_4000_0000;
    localparam logic [63:0] ExtIOLength    = 64'h0000_0000_1000_0000;

    localparam logic [63:0] BOOTBase       = 64'h0000_0000_4000_0000;
    localparam logic [63:0] BOOTLength     = 64'h0000_0000_0001_0000;
    localparam logic [63:0] UARTBase       = 64'h0000_0000_4100_0000;
    localparam logic [63:0] UARTLength     = 64'h0000_0000_0001_0000;
    localparam logic [63:0] SPIBase        = 64'h0000_0000_4200_0000;
    localparam logic [63:0] SPILength      = 64'h0000_0000_0001_0000;
    localparam logic [63:0] EthernetBase   = 64'h0000_0000_4300_0000;
    localparam logic [63:0] EthernetLength = 64'h0000_0000_0001_0000;
    localparam logic [63:0] GPIOBase       = 64'h0000_0000_4400_0000;
    localparam logic [63:0] GPIOLength     = 64'h0000_0000_0001_0000;

    // Start addresses of the I/O bus peripherals, in map order.
    typedef enum logic [63:0] {
        BOOTStart     = 64'h0000_0000_4000_0000,
        UARTStart     = 64'h0000_0000_4100_0000,
        SPIStart      = 64'h0000_0000_4200_0000,
        EthernetStart = 64'h0000_0000_4300_0000,
        GPIOStart     = 64'h0000_0000_4400_0000
    } soc_iobus_start_t;

endpackage

// File: rtl/extio_req_demux_addr_decode.sv
// extio_addr_decode: combinational address-to-target-index decoder.
// Ports:
//   addr  in  AddrWidth  request address
//   idx   out 3          target index (axi_extio_t), or ExtIOErrIdx on no hit
module extio_addr_decode
    import ariane_soc::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr,
    output logic [2:0]           idx
);

    // A window hits when the address, with its in-window offset masked off,
    // equals the window base. Lengths are powers of two.
    function automatic logic hit(input logic [AddrWidth-1:0] a,
                                 input logic [63:0]          base,
                                 input logic [63:0]          len);
        return (a & ~AddrWidth'(len - 64'd1)) == AddrWidth'(base);
    endfunction

    always_comb begin
        idx = 3'(ExtIOErrIdx);
        if (hit(addr, BOOTBase, BOOTLength))         idx = BOOT;
        if (hit(addr, UARTBase, UARTLength))         idx = UART;
        if (hit(addr, SPIBase, SPILength))           idx = SPI;
        if (hit(addr, EthernetBase, EthernetLength)) idx = Ethernet;
        if (hit(addr, GPIOBase, GPIOLength))         idx = GPIO;
    end

endmodule

// File: rtl/extio_req_demux.sv
// extio_req_demux: ExtIO request/response demultiplexer.
// Routes each upstream request to one of five peripheral targets (or an
// internal error responder for unmapped addresses) and returns responses
// in order by only allowing new requests to the target that already has
// responses pending.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   req_valid_i/req_ready_o            upstream request handshake
//   req_addr_i/we_i/wdata_i/be_i       upstream request fields
//   rsp_valid_o/rsp_ready_i            upstream response handshake
//   rsp_rdata_o/rsp_err_o              upstream response fields
//   tgt_req_valid_o/tgt_req_ready_i    per-target request handshake
//   tgt_addr_o/we_o/wdata_o/be_o       broadcast request fields
//   tgt_rsp_valid_i/tgt_rsp_ready_o    per-target response handshake
//   tgt_rsp_rdata_i/tgt_rsp_err_i      per-target response fields
module extio_req_demux
    import ariane_soc::*;
#(
    parameter int unsigned MaxTrans  = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [AddrWidth-1:0]                req_addr_i,
    input  logic                                req_we_i,
    input  logic [DataWidth-1:0]                req_wdata_i,
    input  logic [DataWidth/8-1:0]              req_be_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [DataWidth-1:0]                rsp_rdata_o,
    output logic                                rsp_err_o,
    output logic [NumExtIO-1:0]                 tgt_req_valid_o,
    input  logic [NumExtIO-1:0]                 tgt_req_ready_i,
    output logic [AddrWidth-1:0]                tgt_addr_o,
    output logic                                tgt_we_o,
    output logic [DataWidth-1:0]                tgt_wdata_o,
    output logic [DataWidth/8-1:0]              tgt_be_o,
    input  logic [NumExtIO-1:0]                 tgt_rsp_valid_i,
    output logic [NumExtIO-1:0]                 tgt_rsp_ready_o,
    input  logic [NumExtIO-1:0][DataWidth-1:0]  tgt_rsp_rdata_i,
    input  logic [NumExtIO-1:0]                 tgt_rsp_err_i
);

    localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
    localparam logic [2:0]  ErrIdx   = 3'(ExtIOErrIdx);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [CntWidth-1:0] cnt_q;
    logic [2:0]          cur_q;
    logic [2:0]          dec;
    logic [0:0]          state;
    logic                stall;
    logic                dec_ready;
    logic                req_fire;
    logic                rsp_fire;

    extio_addr_decode #(
        .AddrWidth(AddrWidth)
    ) u_decode (
        .addr(req_addr_i),
        .idx (dec)
    );

    assign state = (cnt_q == '0) ? IDLE : BUSY;

    // Stall on the registered count only, so a full demux stays blocked even
    // when a response drains in the same cycle.
    assign stall = (cnt_q == CntWidth'(MaxTrans)) ||
                   ((state == BUSY) && (dec != cur_q));

    assign tgt_addr_o  = req_addr_i;
    assign tgt_we_o    = req_we_i;
    assign tgt_wdata_o = req_wdata_i;
    assign tgt_be_o    = req_be_i;

    always_comb begin
        tgt_req_valid_o = '0;
        dec_ready       = (dec == ErrIdx);
        for (int unsigned i = 0; i < NumExtIO; i++) begin
            if (dec == 3'(i)) begin
                tgt_req_valid_o[i] = req_valid_i & ~stall;
                dec_ready          = tgt_req_ready_i[i];
            end
        end
        req_ready_o = ~stall & dec_ready;
    end

    // The error responder answers every pending request, one per cycle.
    always_comb begin
        rsp_valid_o     = 1'b0;
        rsp_rdata_o     = '0;
        rsp_err_o       = 1'b0;
        tgt_rsp_ready_o = '0;
        if (state == BUSY) begin
            if (cur_q == ErrIdx) begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NumExtIO; i++) begin
                    if (cur_q == 3'(i)) begin
                        rsp_valid_o        = tgt_rsp_valid_i[i];
                        rsp_rdata_o        = tgt_rsp_rdata_i[i];
                        rsp_err_o          = tgt_rsp_err_i[i];
                        tgt_rsp_ready_o[i] = rsp_ready_i;
                    end
                end
            end
        end
    end

    assign req_fire = req_valid_i & req_ready_o;
    assign rsp_fire = rsp_valid_o & rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            cur_q <= '0;
        end else begin
            if (req_fire) begin
                cur_q <= dec;
            end
            if (req_fire && !rsp_fire) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (rsp_fire && !req_fire) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
        end
    end

endmodule
